seq_load_txn_gen: RTL and testbench
===================================

Name: seq_load_txn_gen

Overview:
- Front end of the sequential-load path. Takes one contiguous load request (byte address, byte length) and splits it into AXI INCR read bursts that never cross a 4 KiB page and never exceed 256 beats.
- Issues the AR channel for each burst.
- Replays each burst as a per-beat transaction-control stream (`txn_ctrl`). The sequential load data controller uses this stream to slice R-channel beats into its lane buffer.

Parameters:
- AxiDataWidth, 128: R bus width in bits. B = AxiDataWidth/8 bytes; busNibbles = AxiDataWidth/4.
- AxiAddrWidth, 64: address width.
- LenWidth, 16: width of the request byte-length field.
- TxnQueueDepth, 4: depth of the burst-info FIFO between the AR side and the txn side.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted
- req_addr_i  in  AxiAddrWidth  start byte address, any alignment
- req_nbytes_i  in  LenWidth  byte count; must be >0
- ar_valid_o  out  1  AXI AR valid
- ar_ready_i  in  1  AXI AR ready
- ar_addr_o  out  AxiAddrWidth  burst start address (unaligned on the first burst only)
- ar_len_o  out  8  beats-1
- ar_size_o  out  3  log2(B)
- ar_burst_o  out  2  always INCR (2'b01)
- txn_ctrl_valid_o  out  1  beat descriptor valid
- txn_ctrl_ready_i  in  1  consumer took the beat
- txn_ctrl_o  out  txn_ctrl_t  {addr, isHead, isFinalTxn, rmnBeat[7:0], lbN[busNSize:0]}

Behaviour:
- Reset: state S_IDLE; req_ready_o=0 during reset, then 1 in S_IDLE; ar_valid_o=0; txn_ctrl_valid_o=0; FIFO empty; all counters 0.
- FSM S_IDLE: req_ready_o=1. On req_valid_i, latch cur_addr=req_addr_i and rmn=req_nbytes_i, then go to S_SPLIT. No AR is issued in the accept cycle.
- FSM S_SPLIT: req_ready_o=0. Burst geometry from cur_addr:
  - A = cur_addr & ~(B-1)
  - P = (cur_addr | 12'hFFF) + 1
  - M = A + 256*B
  - E = cur_addr + rmn
  - end = min(E, P, M)
  - beats = ceil((end-A)/B)
- AR outputs: ar_addr_o=cur_addr, ar_len_o=beats-1, ar_size_o=log2(B), ar_burst_o=INCR.
- AR handshake: ar_valid_o = (state==S_SPLIT) && fifo_enq_ready. AR fire and FIFO enqueue occur in the same cycle, or not at all. While stalled, ar_valid_o and all AR fields stay stable.
- On AR fire:
  - enqueue {addr=cur_addr, len=beats-1, isFinalTxn=(end==E), lbN}. lbN = (end==E) ? 2*(((E-1) mod B)+1) : busNibbles.
  - update cur_addr=end, rmn=rmn-(end-cur_addr).
  - if end==E, go to S_IDLE; the next request is accepted one cycle later at the earliest.
- Geometry arithmetic is done at AxiAddrWidth+1 bits, so address wrap at the top of memory is not masked. A request whose end passes 2^AxiAddrWidth is illegal (assertion).
- Txn side:
  - txn_ctrl_valid_o = fifo_deq_valid.
  - Beat counter bc counts 0..len.
  - txn_ctrl_o fields: addr = entry.addr; isHead = (bc==0); rmnBeat = len-bc; isFinalTxn and lbN come from the entry and are constant across the burst.
- On txn handshake:
  - if rmnBeat==0, pop the entry and clear bc;
  - else bc++.
- Txn output: txn_ctrl_o depends only on the FIFO head and bc; it is stable while valid && !ready.
- Concurrency: the AR side and txn side run independently. A simultaneous enqueue and dequeue on a full FIFO is allowed; the FIFO has no bypass, so txn_ctrl lags AR by at least one cycle.
- Order: txn descriptors are emitted in exactly the AR issue order.
- Reset mid-operation: everything returns to reset values immediately. Partial bursts are dropped. No AR or txn is emitted until a new request arrives.
- Assertions:
  - req_nbytes_i != 0 on request accept;
  - beats ∈ [1,256];
  - lbN ∈ [1, busNibbles];
  - no AR field change while ar_valid_o && !ar_ready_i.

Decomposition:
- Shared package vlsu_pkg: txn_ctrl_t; burst-info FIFO entry type seq_txn_info_t {addr, len, isFinalTxn, lbN}; constants PageBytes=4096 and MaxBurstBeats=256.
- One natural sub-module: the existing QueueFlow instance (T=seq_txn_info_t, DEPTH=TxnQueueDepth) as the burst-info FIFO.
- The geometry arithmetic stays inline.

Test Plan (AxiDataWidth=128: B=16, busNibbles=32):
- Aligned request, addr 0x1000, nbytes 64: one AR {0x1000, len 3, size 4, INCR}; txn beats have rmnBeat 3,2,1,0; isHead only on the first beat; isFinalTxn=1; lbN=32.
- Unaligned request, addr 0x1004, nbytes 20: one AR {0x1004, len 1}; txn beats rmnBeat 1,0; lbN=16; isFinalTxn=1.
- Page crossing, addr 0x1FF0, nbytes 48: first AR {0x1FF0, len 0} with txn isFinalTxn=0, lbN=32; second AR {0x2000, len 1} with txn isFinalTxn=1, lbN=32.
- Page and 256-beat limit coinciding, addr 0x0, nbytes 8192: ARs {0x0, len 255} and {0x1000, len 255}; 512 txn beats; isFinalTxn=1 only on the second burst.
- Backpressure: hold txn_ctrl_ready_i=0 and issue a request that splits into 6 bursts. Exactly 4 ARs fire, then ar_valid_o=0 with stable fields. After ready is released, the remaining 2 ARs fire and all 6 bursts' beats emerge in order. Separately, with ar_ready_i=0 for 5 cycles: AR fields stay stable and nothing is enqueued.
- Reset mid-burst: assert rst_ni=0 after 2 of 4 beats. The same cycle shows ar_valid_o=0 and txn_ctrl_valid_o=0; after release req_ready_o=1. A fresh request at 0x3000 produces a correct single burst with no stale beats.

Source files
------------

// File: rtl/vlsu_pkg.sv
// Shared types for the sequential-load path: per-beat txn descriptor and burst-info FIFO entry.
// Pure declarations, no logic and no latency.
// No flow control lives here; the handshakes are in the modules that use these types.
package vlsu_pkg;

    localparam int unsigned VlsuAxiDataWidth = 128;
    localparam int unsigned VlsuAxiAddrWidth = 64;
    localparam int unsigned BusNibbles       = VlsuAxiDataWidth / 4;
    localparam int unsigned BusNSize         = $clog2(BusNibbles);
    localparam int unsigned PageBytes        = 4096;
    localparam int unsigned MaxBurstBeats    = 256;

    typedef struct packed {
        logic [VlsuAxiAddrWidth-1:0] addr;
        logic                        isHead;
        logic                        isFinalTxn;
        logic [7:0]                  rmnBeat;
        logic [BusNSize:0]           lbN;
    } txn_ctrl_t;

    typedef struct packed {
        logic [VlsuAxiAddrWidth-1:0] addr;
        logic [7:0]                  len;
        logic                        isFinalTxn;
        logic [BusNSize:0]           lbN;
    } seq_txn_info_t;

endpackage

// File: rtl/seq_load_txn_gen_queue.sv
// Generic valid/ready FIFO used as the burst-info queue between the AR and txn sides.
// Latency: one cycle from enqueue to dequeue-visible; no bypass path.
// Backpressure: enq_ready_o drops when full unless a dequeue fires in the same cycle.
module QueueFlow #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enq_valid_i,
    output logic enq_ready_o,
    input  T     enq_data_i,
    output logic deq_valid_o,
    input  logic deq_ready_i,
    output T     deq_data_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    T                mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            enq_fire, deq_fire;

    assign deq_valid_o = (cnt_q != '0);
    assign deq_fire    = deq_valid_o && deq_ready_i;
    assign enq_ready_o = (cnt_q != CntW'(DEPTH)) || deq_fire;
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign deq_data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (enq_fire) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (deq_fire) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (enq_fire && !deq_fire) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (deq_fire && !enq_fire) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem_q[wr_ptr_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/seq_load_txn_gen.sv
// Splits a contiguous load into page-safe, <=256-beat INCR bursts, issues AR, replays per-beat txn_ctrl.
// Latency: request accept -> first AR one cycle; AR fire -> first txn_ctrl beat one cycle.
// Backpressure: AR stalls while the burst-info FIFO is full; txn_ctrl held stable until ready.
module seq_load_txn_gen
    import vlsu_pkg::*;
#(
    parameter int unsigned AxiDataWidth  = VlsuAxiDataWidth,
    parameter int unsigned AxiAddrWidth  = VlsuAxiAddrWidth,
    parameter int unsigned LenWidth      = 16,
    parameter int unsigned TxnQueueDepth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]     req_nbytes_i,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [AxiAddrWidth-1:0] ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    output logic                    txn_ctrl_valid_o,
    input  logic                    txn_ctrl_ready_i,
    output txn_ctrl_t               txn_ctrl_o
);
    localparam int unsigned BusBytes = AxiDataWidth / 8;
    localparam int unsigned BblW     = $clog2(BusBytes);
    localparam int unsigned GeoW     = AxiAddrWidth + 1;
    localparam int unsigned BusNib   = AxiDataWidth / 4;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SPLIT = 1'b1;

    typedef logic [GeoW-1:0] geo_t;

    logic [0:0]              state_q, state_d;
    logic [AxiAddrWidth-1:0] cur_addr_q, cur_addr_d;
    logic [LenWidth-1:0]     rmn_q, rmn_d;
    logic [7:0]              bc_q, bc_d;

    geo_t              cur_ext, base_a, page_end, max_end, req_end, burst_end, span;
    logic [8:0]        beats;
    logic [BblW-1:0]   tail;
    logic              is_final;
    logic [BusNSize:0] lbn;

    logic          req_fire, ar_fire, txn_fire;
    logic          fifo_enq_rdy, fifo_deq_vld, fifo_deq_rdy;
    seq_txn_info_t enq_info, head;
    logic [7:0]    rmn_beat;

    // Extra top bit keeps a burst ending exactly at the top of memory representable.
    always_comb begin
        cur_ext   = {1'b0, cur_addr_q};
        base_a    = cur_ext & ~geo_t'(BusBytes - 1);
        page_end  = (cur_ext | geo_t'(PageBytes - 1)) + geo_t'(1);
        max_end   = base_a + geo_t'(MaxBurstBeats * BusBytes);
        req_end   = cur_ext + geo_t'(rmn_q);
        burst_end = req_end;
        if (page_end < burst_end) burst_end = page_end;
        if (max_end < burst_end)  burst_end = max_end;
        is_final  = (burst_end == req_end);
        span      = burst_end - base_a;
        beats     = span[BblW+8:BblW] + 9'(|span[BblW-1:0]);
        tail      = req_end[BblW-1:0] - BblW'(1);
        lbn       = is_final ? {({1'b0, tail} + (BblW+1)'(1)), 1'b0} : (BusNSize+1)'(BusNib);
    end

    assign req_ready_o = (state_q == S_IDLE) && rst_ni;
    assign req_fire    = req_valid_i && req_ready_o;
    assign ar_valid_o  = (state_q == S_SPLIT) && fifo_enq_rdy;
    assign ar_fire     = ar_valid_o && ar_ready_i;
    assign ar_addr_o   = cur_addr_q;
    assign ar_len_o    = 8'(beats - 9'd1);
    assign ar_size_o   = 3'(BblW);
    assign ar_burst_o  = 2'b01;

    assign enq_info = '{addr: cur_addr_q, len: ar_len_o, isFinalTxn: is_final, lbN: lbn};

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rmn_d      = rmn_q;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    cur_addr_d = req_addr_i;
                    rmn_d      = req_nbytes_i;
                    state_d    = S_SPLIT;
                end
            end
            S_SPLIT: begin
                if (ar_fire) begin
                    cur_addr_d = burst_end[AxiAddrWidth-1:0];
                    rmn_d      = rmn_q - LenWidth'(burst_end - cur_ext);
                    if (is_final) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    QueueFlow #(
        .T     (seq_txn_info_t),
        .DEPTH (TxnQueueDepth)
    ) u_info_q (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enq_valid_i (ar_fire),
        .enq_ready_o (fifo_enq_rdy),
        .enq_data_i  (enq_info),
        .deq_valid_o (fifo_deq_vld),
        .deq_ready_i (fifo_deq_rdy),
        .deq_data_o  (head)
    );

    assign rmn_beat         = head.len - bc_q;
    assign txn_ctrl_valid_o = fifo_deq_vld;
    assign txn_fire         = fifo_deq_vld && txn_ctrl_ready_i;
    assign fifo_deq_rdy     = txn_ctrl_ready_i && (rmn_beat == 8'd0);
    assign txn_ctrl_o       = '{addr:       head.addr,
                                isHead:     (bc_q == 8'd0),
                                isFinalTxn: head.isFinalTxn,
                                rmnBeat:    rmn_beat,
                                lbN:        head.lbN};

    always_comb begin
        bc_d = bc_q;
        if (txn_fire) begin
            bc_d = (rmn_beat == 8'd0) ? 8'd0 : bc_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            rmn_q      <= '0;
            bc_q       <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rmn_q      <= rmn_d;
            bc_q       <= bc_d;
        end
    end

    a_nbytes_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_fire |-> (req_nbytes_i != '0));
    a_beats_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == S_SPLIT) |-> (beats >= 9'd1 && beats <= 9'd256 && span[GeoW-1:BblW+9] == '0));
    a_lbn_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ar_fire |-> (lbn >= (BusNSize+1)'(1) && lbn <= (BusNSize+1)'(BusNib)));
    a_no_wrap: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == S_SPLIT) |-> (req_end <= (geo_t'(1) << AxiAddrWidth)));
    a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ar_valid_o && !ar_ready_i) |=> ($stable(ar_addr_o) && $stable(ar_len_o)));

endmodule

// File: tb/tb_seq_load_txn_gen.sv
// Directed bench for seq_load_txn_gen: table of requests with hand-computed bursts plus corner sequences.
module tb_seq_load_txn_gen;
    import vlsu_pkg::*;

    typedef struct {
        logic [63:0] addr;
        logic [15:0] nbytes;
    } req_vec_t;

    typedef struct {
        int          req;
        logic [63:0] addr;
        logic [7:0]  len;
        logic        fin;
        logic [5:0]  lbn;
    } burst_vec_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr_i = '0;
    logic [15:0] req_nbytes_i = '0;
    logic        ar_valid_o;
    logic        ar_ready_i = 1'b0;
    logic [63:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        txn_ctrl_valid_o;
    logic        txn_ctrl_ready_i = 1'b0;
    txn_ctrl_t   txn_ctrl_o;

    int checks = 0;
    int errors = 0;
    int ar_fires = 0;
    int beats_seen = 0;
    bit mon_en = 1'b0;
    bit rand_rdy = 1'b0;
    bit ar_rdy_fix = 1'b1;
    bit txn_rdy_fix = 1'b1;
    bit prev_stall = 1'b0;
    logic [63:0] prev_addr;
    logic [7:0]  prev_len;

    burst_vec_t exp_ar[$];
    txn_ctrl_t  exp_beat[$];

    seq_load_txn_gen dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_nbytes_i     (req_nbytes_i),
        .ar_valid_o       (ar_valid_o),
        .ar_ready_i       (ar_ready_i),
        .ar_addr_o        (ar_addr_o),
        .ar_len_o         (ar_len_o),
        .ar_size_o        (ar_size_o),
        .ar_burst_o       (ar_burst_o),
        .txn_ctrl_valid_o (txn_ctrl_valid_o),
        .txn_ctrl_ready_i (txn_ctrl_ready_i),
        .txn_ctrl_o       (txn_ctrl_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            ar_ready_i       = ($urandom_range(0, 3) != 0);
            txn_ctrl_ready_i = ($urandom_range(0, 3) != 0);
        end else begin
            ar_ready_i       = ar_rdy_fix;
            txn_ctrl_ready_i = txn_rdy_fix;
        end
    end

    // Handshakes sampled at negedge complete on the following posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            burst_vec_t e;
            txn_ctrl_t  b;
            if (prev_stall) begin
                chk("ar_stable_addr", ar_addr_o, prev_addr);
                chk("ar_stable_len", ar_len_o, prev_len);
            end
            prev_stall = ar_valid_o && !ar_ready_i;
            prev_addr  = ar_addr_o;
            prev_len   = ar_len_o;
            if (ar_valid_o && ar_ready_i) begin
                ar_fires++;
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", 1, 0);
                end else begin
                    e = exp_ar.pop_front();
                    chk("ar_addr", ar_addr_o, e.addr);
                    chk("ar_len", ar_len_o, e.len);
                    chk("ar_size", ar_size_o, 3'd4);
                    chk("ar_burst", ar_burst_o, 2'b01);
                end
            end
            if (txn_ctrl_valid_o && txn_ctrl_ready_i) begin
                beats_seen++;
                if (exp_beat.size() == 0) begin
                    chk("txn_unexpected", 1, 0);
                end else begin
                    b = exp_beat.pop_front();
                    chk("txn_beat", txn_ctrl_o, b);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input burst_vec_t bv);
        txn_ctrl_t t;
        exp_ar.push_back(bv);
        for (int k = 0; k <= int'(bv.len); k++) begin
            t = '{addr: bv.addr, isHead: (k == 0), isFinalTxn: bv.fin,
                  rmnBeat: 8'(int'(bv.len) - k), lbN: bv.lbn};
            exp_beat.push_back(t);
        end
    endtask

    task automatic issue(input logic [63:0] addr, input logic [15:0] n);
        bit ok = 1'b0;
        req_addr_i   = addr;
        req_nbytes_i = n;
        req_valid_i  = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (req_ready_o) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        chk("req_accepted", ok, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (exp_ar.size() == 0 && exp_beat.size() == 0 && req_ready_o) done = 1'b1;
        end
        chk("drain_timeout", done, 1'b1);
        tick(1);
    endtask

    req_vec_t   reqs[7];
    burst_vec_t bursts[11];
    burst_vec_t bp_bursts[6];

    initial begin
        int base;
        bit hit;

        reqs[0] = '{64'h1000,  16'd64};
        reqs[1] = '{64'h1004,  16'd20};
        reqs[2] = '{64'h1FF0,  16'd48};
        reqs[3] = '{64'h0,     16'd8192};
        reqs[4] = '{64'h5003,  16'd1};
        reqs[5] = '{64'h7FF8,  16'd48};
        reqs[6] = '{64'h10008, 16'd4096};
        bursts[0]  = '{0, 64'h1000,  8'd3,   1'b1, 6'd32};
        bursts[1]  = '{1, 64'h1004,  8'd1,   1'b1, 6'd16};
        bursts[2]  = '{2, 64'h1FF0,  8'd0,   1'b0, 6'd32};
        bursts[3]  = '{2, 64'h2000,  8'd1,   1'b1, 6'd32};
        bursts[4]  = '{3, 64'h0,     8'd255, 1'b0, 6'd32};
        bursts[5]  = '{3, 64'h1000,  8'd255, 1'b1, 6'd32};
        bursts[6]  = '{4, 64'h5003,  8'd0,   1'b1, 6'd8};
        bursts[7]  = '{5, 64'h7FF8,  8'd0,   1'b0, 6'd32};
        bursts[8]  = '{5, 64'h8000,  8'd2,   1'b1, 6'd16};
        bursts[9]  = '{6, 64'h10008, 8'd255, 1'b0, 6'd32};
        bursts[10] = '{6, 64'h11000, 8'd0,   1'b1, 6'd16};
        bp_bursts[0] = '{0, 64'h0FF0, 8'd0,   1'b0, 6'd32};
        bp_bursts[1] = '{0, 64'h1000, 8'd255, 1'b0, 6'd32};
        bp_bursts[2] = '{0, 64'h2000, 8'd255, 1'b0, 6'd32};
        bp_bursts[3] = '{0, 64'h3000, 8'd255, 1'b0, 6'd32};
        bp_bursts[4] = '{0, 64'h4000, 8'd255, 1'b0, 6'd32};
        bp_bursts[5] = '{0, 64'h5000, 8'd0,   1'b1, 6'd32};

        #2;
        chk("rst_req_ready", req_ready_o, 1'b0);
        chk("rst_ar_valid", ar_valid_o, 1'b0);
        chk("rst_txn_valid", txn_ctrl_valid_o, 1'b0);
        #20;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready_o, 1'b1);
        chk("post_rst_ar_valid", ar_valid_o, 1'b0);
        mon_en = 1'b1;
        tick(1);

        for (int r = 0; r < 7; r++) begin
            rand_rdy = (r >= 2);
            for (int i = 0; i < 11; i++) begin
                if (bursts[i].req == r) push_burst(bursts[i]);
            end
            issue(reqs[r].addr, reqs[r].nbytes);
            wait_done(3000);
        end
        rand_rdy = 1'b0;

        // Txn side held off: the FIFO fills after 4 bursts and AR stalls.
        txn_rdy_fix = 1'b0;
        ar_rdy_fix  = 1'b1;
        tick(2);
        for (int i = 0; i < 6; i++) push_burst(bp_bursts[i]);
        base = ar_fires;
        issue(64'h0FF0, 16'd16416);
        tick(20);
        @(negedge clk);
        chk("bp_ar_count", ar_fires - base, 4);
        chk("bp_ar_valid", ar_valid_o, 1'b0);
        chk("bp_ar_addr", ar_addr_o, 64'h4000);
        chk("bp_ar_len", ar_len_o, 8'd255);
        chk("bp_txn_valid", txn_ctrl_valid_o, 1'b1);
        chk("bp_txn_head", {txn_ctrl_o.addr, txn_ctrl_o.isHead}, {64'h0FF0, 1'b1});
        tick(3);
        @(negedge clk);
        chk("bp_ar_addr_hold", ar_addr_o, 64'h4000);
        chk("bp_ar_count_hold", ar_fires - base, 4);
        txn_rdy_fix = 1'b1;
        wait_done(4000);

        // AR channel stalled for 5 cycles: nothing may reach the txn side.
        ar_rdy_fix = 1'b0;
        tick(2);
        push_burst('{0, 64'h1004, 8'd1, 1'b1, 6'd16});
        issue(64'h1004, 16'd20);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("arstall_valid", ar_valid_o, 1'b1);
            chk("arstall_addr", ar_addr_o, 64'h1004);
            chk("arstall_len", ar_len_o, 8'd1);
            chk("arstall_no_txn", txn_ctrl_valid_o, 1'b0);
        end
        tick(1);
        ar_rdy_fix = 1'b1;
        wait_done(200);

        // Reset after 2 of 4 beats.
        push_burst('{0, 64'h1000, 8'd3, 1'b1, 6'd32});
        base = beats_seen;
        issue(64'h1000, 16'd64);
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(posedge clk);
            if (beats_seen - base == 2) hit = 1'b1;
        end
        chk("mid_rst_reach_2_beats", hit, 1'b1);
        #1;
        rst_ni = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("mid_rst_ar_valid", ar_valid_o, 1'b0);
        chk("mid_rst_txn_valid", txn_ctrl_valid_o, 1'b0);
        chk("mid_rst_req_ready", req_ready_o, 1'b0);
        exp_ar.delete();
        exp_beat.delete();
        tick(2);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", req_ready_o, 1'b1);
        chk("rel_txn_valid", txn_ctrl_valid_o, 1'b0);
        mon_en = 1'b1;
        tick(1);
        push_burst('{0, 64'h3000, 8'd1, 1'b1, 6'd32});
        base = beats_seen;
        issue(64'h3000, 16'd32);
        wait_done(200);
        chk("fresh_beat_count", beats_seen - base, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
